// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared constants and decode helpers for the MEM stage
package mem_stage_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE     = 2'd0;
   localparam state_t ST_REQ      = 2'd1;
   localparam state_t ST_WAIT_RSP = 2'd2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam int CTL_MEM_READ  = 0;
   localparam int CTL_MEM_WRITE = 1;

   // Memory op that must complete without touching dmem (bad code or misaligned).
   function automatic logic is_squash(input logic [1:0] ctl, input logic [2:0] f3,
                                      input logic [1:0] off);
      logic bad_f3;
      logic mis;
      if (ctl[CTL_MEM_WRITE])
         bad_f3 = !(f3 inside {F3_SB, F3_SH, F3_SW});
      else
         bad_f3 = !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
      mis = ((f3[1:0] == F3_LH[1:0]) && off[0]) ||
            ((f3[1:0] == F3_LW[1:0]) && (off != 2'b00));
      return (ctl[CTL_MEM_READ] && ctl[CTL_MEM_WRITE]) || bad_f3 || mis;
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3[1:0])
         F3_SB[1:0]: be = 4'b0001 << off;
         F3_SH[1:0]: be = off[1] ? 4'b1100 : 4'b0011;
         default:    be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] d;
      case (f3[1:0])
         F3_SB[1:0]: d = {4{wd[7:0]}};
         F3_SH[1:0]: d = {2{wd[15:0]}};
         default:    d = wd;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - picks the addressed lane of a load word and extends it
module load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[{offset, 3'b000} +: 8];
      half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
         F3_LH:   data = {{16{half_lane[15]}}, half_lane};
         F3_LBU:  data = {24'd0, byte_lane};
         F3_LHU:  data = {16'd0, half_lane};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_pip.sv
// rtl/mem_stage_pip.sv - pipeline MEM stage with stalling dmem handshake and WB register
module mem_stage_pip
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        valid_MEM_in,
   input  logic [1:0]  control_MEM_in,
   input  logic [1:0]  control_WB_in,
   input  logic [2:0]  funct3_MEM_in,
   input  logic [31:0] ALU_result_MEM_in,
   input  logic [31:0] writeData_MEM_in,
   input  logic [4:0]  rd_MEM_in,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_req_we,
   output logic [31:0] dmem_req_addr,
   output logic [31:0] dmem_req_wdata,
   output logic [3:0]  dmem_req_be,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rsp_rdata,
   output logic        stall_MEM_out,
   output logic        valid_WB_out,
   output logic [1:0]  control_WB_out,
   output logic [31:0] readData_WB_out,
   output logic [31:0] ALU_result_WB_out,
   output logic [4:0]  rd_WB_out,
   output logic        misaligned_out,
   output logic        timeout_out
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             cnt_last;
   logic             squash;
   logic             stall_c;
   logic [1:0]       lat_wbc;
   logic [31:0]      lat_alu;
   logic [4:0]       lat_rd;
   logic [2:0]       lat_f3;
   logic [31:0]      load_data;

   assign squash   = is_squash(control_MEM_in, funct3_MEM_in, ALU_result_MEM_in[1:0]);
   assign cnt_last = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   load_align u_load_align (
      .rdata  (dmem_rsp_rdata),
      .offset (lat_alu[1:0]),
      .funct3 (lat_f3),
      .data   (load_data)
   );

   always_comb begin
      stall_c = 1'b0;
      case (state)
         ST_IDLE:     stall_c = valid_MEM_in && (control_MEM_in != 2'b00) && !squash;
         ST_REQ:      stall_c = !(dmem_req_ready && dmem_req_we);
         ST_WAIT_RSP: stall_c = !dmem_rsp_valid && !cnt_last;
         default:     stall_c = 1'b0;
      endcase
   end

   // Gated so the stall drops the instant reset asserts, not at the next edge.
   assign stall_MEM_out = reset_n & stall_c;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state             <= ST_IDLE;
         cnt               <= '0;
         dmem_req_valid    <= 1'b0;
         dmem_req_we       <= 1'b0;
         dmem_req_addr     <= '0;
         dmem_req_wdata    <= '0;
         dmem_req_be       <= '0;
         valid_WB_out      <= 1'b0;
         control_WB_out    <= '0;
         readData_WB_out   <= '0;
         ALU_result_WB_out <= '0;
         rd_WB_out         <= '0;
         misaligned_out    <= 1'b0;
         timeout_out       <= 1'b0;
         lat_wbc           <= '0;
         lat_alu           <= '0;
         lat_rd            <= '0;
         lat_f3            <= '0;
      end else begin
         valid_WB_out   <= 1'b0;
         control_WB_out <= 2'b00;
         misaligned_out <= 1'b0;
         timeout_out    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (valid_MEM_in) begin
                  if (control_MEM_in == 2'b00) begin
                     valid_WB_out      <= 1'b1;
                     control_WB_out    <= control_WB_in;
                     ALU_result_WB_out <= ALU_result_MEM_in;
                     rd_WB_out         <= rd_MEM_in;
                  end else if (squash) begin
                     valid_WB_out      <= 1'b1;
                     ALU_result_WB_out <= ALU_result_MEM_in;
                     rd_WB_out         <= rd_MEM_in;
                     misaligned_out    <= 1'b1;
                  end else begin
                     dmem_req_valid <= 1'b1;
                     dmem_req_we    <= control_MEM_in[CTL_MEM_WRITE];
                     dmem_req_addr  <= {ALU_result_MEM_in[31:2], 2'b00};
                     dmem_req_wdata <= store_data(funct3_MEM_in, writeData_MEM_in);
                     dmem_req_be    <= store_be(funct3_MEM_in, ALU_result_MEM_in[1:0]);
                     lat_wbc        <= control_WB_in;
                     lat_alu        <= ALU_result_MEM_in;
                     lat_rd         <= rd_MEM_in;
                     lat_f3         <= funct3_MEM_in;
                     state          <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (dmem_req_ready) begin
                  dmem_req_valid <= 1'b0;
                  if (dmem_req_we) begin
                     valid_WB_out      <= 1'b1;
                     control_WB_out    <= lat_wbc;
                     ALU_result_WB_out <= lat_alu;
                     rd_WB_out         <= lat_rd;
                     state             <= ST_IDLE;
                  end else begin
                     cnt   <= '0;
                     state <= ST_WAIT_RSP;
                  end
               end
            end
            ST_WAIT_RSP: begin
               if (dmem_rsp_valid) begin
                  valid_WB_out      <= 1'b1;
                  control_WB_out    <= lat_wbc;
                  readData_WB_out   <= load_data;
                  ALU_result_WB_out <= lat_alu;
                  rd_WB_out         <= lat_rd;
                  cnt               <= '0;
                  state             <= ST_IDLE;
               end else if (cnt_last) begin
                  // Aborted load retires with no register write.
                  valid_WB_out      <= 1'b1;
                  ALU_result_WB_out <= lat_alu;
                  rd_WB_out         <= lat_rd;
                  timeout_out       <= 1'b1;
                  cnt               <= '0;
                  state             <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_pip.sv
// tb/tb_mem_stage_pip.sv - scoreboard bench for mem_stage_pip
module tb_mem_stage_pip;

   localparam int TO = 4;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        valid_MEM_in;
   logic [1:0]  control_MEM_in;
   logic [1:0]  control_WB_in;
   logic [2:0]  funct3_MEM_in;
   logic [31:0] ALU_result_MEM_in;
   logic [31:0] writeData_MEM_in;
   logic [4:0]  rd_MEM_in;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic        dmem_req_we;
   logic [31:0] dmem_req_addr;
   logic [31:0] dmem_req_wdata;
   logic [3:0]  dmem_req_be;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_rdata;
   logic        stall_MEM_out;
   logic        valid_WB_out;
   logic [1:0]  control_WB_out;
   logic [31:0] readData_WB_out;
   logic [31:0] ALU_result_WB_out;
   logic [4:0]  rd_WB_out;
   logic        misaligned_out;
   logic        timeout_out;

   mem_stage_pip #(.TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset_n(reset_n),
      .valid_MEM_in(valid_MEM_in), .control_MEM_in(control_MEM_in),
      .control_WB_in(control_WB_in), .funct3_MEM_in(funct3_MEM_in),
      .ALU_result_MEM_in(ALU_result_MEM_in), .writeData_MEM_in(writeData_MEM_in),
      .rd_MEM_in(rd_MEM_in),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
      .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
      .stall_MEM_out(stall_MEM_out), .valid_WB_out(valid_WB_out),
      .control_WB_out(control_WB_out), .readData_WB_out(readData_WB_out),
      .ALU_result_WB_out(ALU_result_WB_out), .rd_WB_out(rd_WB_out),
      .misaligned_out(misaligned_out), .timeout_out(timeout_out)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  ctl;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic [31:0] rdata;
      bit          chk_rdata;
      bit          mis;
      bit          to;
   } wb_exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_exp_t;

   wb_exp_t  wb_q[$];
   req_exp_t req_q[$];
   int       n_vec = 0;
   int       n_err = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference rules, written from the instruction-set view of each access.
   function automatic bit model_squash(input logic [1:0] ctl, input logic [2:0] f3, input logic [1:0] off);
      int w;
      bit legal;
      w = f3 % 4;
      if (ctl == 2'b11) return 1;
      if (ctl == 2'b10) legal = (f3 <= 2);
      else              legal = (f3 <= 2) || (f3 == 4) || (f3 == 5);
      if (!legal) return 1;
      if (w == 1 && (off % 2) != 0) return 1;
      if (w == 2 && off != 0) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [2:0] f3, input logic [1:0] off);
      logic [31:0] v;
      v = rdata >> (8 * off);
      case (f3)
         3'd0: begin v = v & 32'hFF;   if (v >= 128)   v = v - 32'd256;   end
         3'd1: begin v = v & 32'hFFFF; if (v >= 32768) v = v - 32'd65536; end
         3'd4: v = v & 32'hFF;
         3'd5: v = v & 32'hFFFF;
         default: v = rdata;
      endcase
      return v;
   endfunction

   function automatic req_exp_t model_req(input logic [1:0] ctl, input logic [2:0] f3,
                                          input logic [31:0] alu, input logic [31:0] wd);
      req_exp_t r;
      int off;
      off    = alu % 4;
      r.we   = (ctl == 2'b10);
      r.addr = alu - off;
      case (f3 % 4)
         0: begin r.wdata = (wd & 32'hFF) * 32'h0101_0101;   r.be = 4'(1 << off); end
         1: begin r.wdata = (wd & 32'hFFFF) * 32'h0001_0001; r.be = (off == 2) ? 4'd12 : 4'd3; end
         default: begin r.wdata = wd; r.be = 4'd15; end
      endcase
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_op(input logic v, input logic [1:0] ctl, input logic [1:0] wbc,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd, input int rdly, input int rspdly,
                        input bit give_rsp, input logic [31:0] rdata);
      wb_exp_t e;
      bit mem, sq, is_load;
      valid_MEM_in = v; control_MEM_in = ctl; control_WB_in = wbc; funct3_MEM_in = f3;
      ALU_result_MEM_in = alu; writeData_MEM_in = wd; rd_MEM_in = rd;
      mem     = v && (ctl != 2'b00);
      sq      = mem && model_squash(ctl, f3, alu[1:0]);
      is_load = mem && !sq && (ctl == 2'b01);
      if (v) begin
         e.ctl       = (sq || (is_load && !give_rsp)) ? 2'b00 : wbc;
         e.alu       = alu;
         e.rd        = rd;
         e.rdata     = model_load(rdata, f3, alu[1:0]);
         e.chk_rdata = is_load && give_rsp;
         e.mis       = sq;
         e.to        = is_load && !give_rsp;
         wb_q.push_back(e);
      end
      if (mem && !sq) req_q.push_back(model_req(ctl, f3, alu, wd));
      if (!mem || sq) begin
         @(negedge clock); chk("stall_single", stall_MEM_out, 0);
         tick();
         dmem_rsp_valid = 1'b0;
         return;
      end
      @(negedge clock); chk("stall_issue", stall_MEM_out, 1);
      tick();
      repeat (rdly) begin
         dmem_rsp_valid = 1'($urandom_range(0, 1));
         @(negedge clock); chk("stall_req", stall_MEM_out, 1);
         tick();
      end
      dmem_req_ready = 1'b1;
      dmem_rsp_valid = 1'($urandom_range(0, 1));
      @(negedge clock); chk("stall_accept", stall_MEM_out, is_load ? 1 : 0);
      tick();
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      if (!is_load) return;
      if (give_rsp) begin
         repeat (rspdly) begin
            @(negedge clock); chk("stall_wait", stall_MEM_out, 1);
            tick();
         end
         dmem_rsp_valid = 1'b1; dmem_rsp_rdata = rdata;
         @(negedge clock); chk("stall_rsp", stall_MEM_out, 0);
         tick();
         dmem_rsp_valid = 1'b0;
      end else begin
         repeat (TO - 1) begin
            @(negedge clock); chk("stall_wait_to", stall_MEM_out, 1);
            tick();
         end
         @(negedge clock); chk("stall_abort", stall_MEM_out, 0);
         tick();
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stall"}, stall_MEM_out, 0);
      chk({tag, "_req_valid"}, dmem_req_valid, 0);
      chk({tag, "_req_fields"}, {dmem_req_we, dmem_req_be, dmem_req_addr[26:0]}, 0);
      chk({tag, "_req_wdata"}, dmem_req_wdata, 0);
      chk({tag, "_wb_valid_ctl_rd"}, {valid_WB_out, control_WB_out, rd_WB_out}, 0);
      chk({tag, "_wb_rdata"}, readData_WB_out, 0);
      chk({tag, "_wb_alu"}, ALU_result_WB_out, 0);
      chk({tag, "_pulses"}, {misaligned_out, timeout_out}, 0);
   endtask

   // WB monitor: every completion pops one expectation.
   always @(negedge clock) begin : wb_mon
      wb_exp_t e;
      if (reset_n) begin
         if (valid_WB_out) begin
            if (wb_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL wb_unexpected: valid_WB_out=1 with nothing outstanding at %0t", $time);
            end else begin
               e = wb_q.pop_front();
               chk("wb_ctl", control_WB_out, e.ctl);
               chk("wb_alu", ALU_result_WB_out, e.alu);
               chk("wb_rd", rd_WB_out, e.rd);
               chk("wb_misaligned", misaligned_out, e.mis);
               chk("wb_timeout", timeout_out, e.to);
               if (e.chk_rdata) chk("wb_rdata", readData_WB_out, e.rdata);
            end
         end else begin
            chk("bubble_ctl", control_WB_out, 0);
            chk("bubble_pulses", {misaligned_out, timeout_out}, 0);
         end
      end
   end

   // dmem request monitor: fields must match and hold until accepted.
   always @(negedge clock) begin : req_mon
      req_exp_t r;
      if (reset_n && dmem_req_valid) begin
         if (req_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL req_unexpected: dmem_req_valid=1 addr %h with nothing outstanding at %0t",
                     dmem_req_addr, $time);
         end else begin
            r = req_q[0];
            chk("req_we", dmem_req_we, r.we);
            chk("req_addr", dmem_req_addr, r.addr);
            if (r.we) begin
               chk("req_wdata", dmem_req_wdata, r.wdata);
               chk("req_be", dmem_req_be, r.be);
            end
            if (dmem_req_ready) void'(req_q.pop_front());
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [1:0]  ctl;
      logic [2:0]  f3;
      logic [31:0] alu;
      int          r;
      reset_n = 1'b0;
      valid_MEM_in = 1'b1; control_MEM_in = 2'b01; control_WB_in = 2'b11;
      funct3_MEM_in = 3'b010; ALU_result_MEM_in = 32'h40; writeData_MEM_in = 32'h0;
      rd_MEM_in = 5'd1; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = 32'h0;
      #12;
      chk_all_zero("reset");
      valid_MEM_in = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();

      do_op(1, 2'b00, 2'b10, 3'd0, 32'h0000_1234, 32'h0, 5'd3, 0, 0, 0, 32'h0);
      do_op(1, 2'b01, 2'b11, 3'b000, 32'h0000_0103, 32'h0, 5'd4, 2, 3, 1, 32'h80FF_0000);
      do_op(1, 2'b10, 2'b00, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 0, 0, 0, 32'h0);
      do_op(1, 2'b01, 2'b11, 3'b010, 32'h0000_0101, 32'h0, 5'd5, 0, 0, 0, 32'h0);
      do_op(1, 2'b01, 2'b11, 3'b010, 32'h0000_0100, 32'h0, 5'd6, 1, 0, 0, 32'h0);
      dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'hDEAD_BEEF;
      do_op(0, 2'b00, 2'b11, 3'd0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0);
      do_op(1, 2'b11, 2'b11, 3'b000, 32'h0000_0010, 32'h0, 5'd7, 0, 0, 0, 32'h0);

      // Reset while a load is waiting for its response.
      valid_MEM_in = 1'b1; control_MEM_in = 2'b01; control_WB_in = 2'b11;
      funct3_MEM_in = 3'b010; ALU_result_MEM_in = 32'h300; rd_MEM_in = 5'd9;
      req_q.push_back(model_req(2'b01, 3'b010, 32'h300, 32'h0));
      tick();
      dmem_req_ready = 1'b1;
      tick();
      dmem_req_ready = 1'b0;
      tick();
      #2 reset_n = 1'b0;
      #1 chk_all_zero("midreset");
      valid_MEM_in = 1'b0;
      req_q.delete();
      tick();
      reset_n = 1'b1;
      tick();
      do_op(1, 2'b01, 2'b11, 3'b101, 32'h0000_0302, 32'h0, 5'd9, 1, 1, 1, 32'h8001_7FFF);

      for (int i = 0; i < 250; i++) begin
         r   = $urandom_range(0, 9);
         ctl = (r <= 2) ? 2'b00 : (r <= 5) ? 2'b01 : (r <= 8) ? 2'b10 : 2'b11;
         f3  = 3'($urandom_range(0, 7));
         alu = $urandom;
         if ($urandom_range(0, 2) != 0) begin
            if (f3[1:0] == 2'b10) alu[1:0] = 2'b00;
            if (f3[1:0] == 2'b01) alu[0] = 1'b0;
         end
         dmem_rsp_valid = ($urandom_range(0, 3) == 0);
         dmem_rsp_rdata = $urandom;
         do_op(1'($urandom_range(0, 7) != 0), ctl, 2'($urandom_range(0, 3)), f3, alu, $urandom,
               5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, TO - 1),
               $urandom_range(0, 4) != 0, $urandom);
      end

      valid_MEM_in = 1'b0;
      repeat (3) tick();
      chk("wb_queue_drained", wb_q.size(), 0);
      chk("req_queue_drained", req_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage_pip.md
MEM_STAGE_PIP -- requirements
Module: mem_stage_pip

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, max cycles spent in WAIT_RSP before abort.
REQ-002 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port valid_MEM_in  in  1  instruction in MEM is valid.
REQ-005 SHALL have port control_MEM_in  in  2  [0] MemRead, [1] MemWrite.
REQ-006 SHALL have port control_WB_in  in  2  WB controls: [0] MemtoReg, [1] RegWrite.
REQ-007 SHALL have port funct3_MEM_in  in  3  access width/sign code.
REQ-008 SHALL have port ALU_result_MEM_in  in  32  byte address, or result for non-memory ops.
REQ-009 SHALL have port writeData_MEM_in  in  32  store data (rs2).
REQ-010 SHALL have port rd_MEM_in  in  5  destination register.
REQ-011 SHALL have ports dmem_req_valid out 1, dmem_req_ready in 1, dmem_req_we out 1, dmem_req_addr out 32, dmem_req_wdata out 32, dmem_req_be out 4.
REQ-012 SHALL have ports dmem_rsp_valid in 1, dmem_rsp_rdata in 32.
REQ-013 SHALL have port stall_MEM_out  out  1  hold IF/ID/EX and the MEM inputs.
REQ-014 SHALL have registered ports valid_WB_out 1, control_WB_out 2, readData_WB_out 32, ALU_result_WB_out 32, rd_WB_out 5.
REQ-015 SHALL have ports misaligned_out out 1 and timeout_out out 1, each a one-cycle pulse.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT_RSP.
REQ-017 Non-memory op (valid, control_MEM_in=00): in IDLE, WB registers capture the inputs at the next edge; stall_MEM_out=0; latency 1.
REQ-018 Memory op in IDLE: stall_MEM_out=1; next state REQ; dmem_req_valid registered high from the next cycle.
REQ-019 In REQ: hold valid, addr, we, wdata, and be stable until dmem_req_ready=1.
REQ-020 dmem_req_addr SHALL be {ALU_result[31:2],2'b00}.
REQ-021 Store accept (REQ with ready=1): stall_MEM_out=0 that cycle; WB registers capture; valid_WB_out=1; go to IDLE.
REQ-022 Load accept: go to WAIT_RSP; stall held at 1.
REQ-023 In WAIT_RSP with dmem_rsp_valid=1: stall_MEM_out=0; readData_WB_out captures the aligned, extended data; go to IDLE.
REQ-024 Load funct3 decode: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend; lane selected by addr[1:0].
REQ-025 Store funct3 decode: 000 SB, be=0001<<addr[1:0], byte replicated x4; 001 SH, be=0011 or 1100, half replicated x2; 010 SW, be=1111.
REQ-026 Squash cases: halfword with addr[0]=1, word with addr[1:0]!=0, reserved funct3, or control_MEM_in=11. Required response: no dmem request; completes in IDLE with latency 1; control_WB_out forced to 00; misaligned_out pulses.
REQ-027 WAIT_RSP counter reaching TIMEOUT_CYCLES: abort and return to IDLE; complete squashed (control_WB_out=00); timeout_out pulses; a later stale dmem_rsp_valid seen in IDLE SHALL be ignored.
REQ-028 valid_MEM_in=0 in IDLE: valid_WB_out=0 and control_WB_out=00 at the next edge.
REQ-029 While stall_MEM_out=1: WB registers hold valid_WB_out=0 and control_WB_out=00 (bubble); no other update.
REQ-030 dmem_rsp_valid in REQ or IDLE SHALL be ignored.

Reset
REQ-031 reset_n low SHALL asynchronously force state IDLE, counter 0, and every output 0, including dmem_req_valid and stall_MEM_out.
REQ-032 Reset mid-transaction SHALL drop dmem_req_valid immediately, with no completion and no pulse.

Structure
REQ-033 Package mem_stage_pkg SHALL hold the state enum, funct3 load/store codes, and control bit indices.
REQ-034 Combinational sub-module load_align SHALL perform lane select and sign/zero extension.

Verification
REQ-035 Non-memory op: ALU_result=0x0000_1234, control 00 -> next cycle ALU_result_WB_out=0x1234, valid_WB_out=1, stall never high.
REQ-036 LB at addr 0x103, rdata=0x80FF_0000, ready after 2 cycles, rsp 3 cycles later -> readData_WB_out=0xFFFF_FF80; stall high until the rsp cycle.
REQ-037 SH at 0x202, data 0x0000_ABCD -> be=1100, wdata=0xABCD_ABCD, addr 0x200; complete on accept.
REQ-038 LW at 0x101 -> no dmem_req_valid, misaligned_out one pulse, control_WB_out=00.
REQ-039 LW with no rsp, TIMEOUT_CYCLES=4 -> timeout_out pulses after 4 WAIT cycles; a late rsp is ignored.
REQ-040 reset_n low during WAIT_RSP -> all outputs 0 asynchronously; the next op proceeds normally.
